insmem_loader: RTL
==================

// Module: insmem_loader
// PURPOSE
//  Write-side companion to the instruction memory. Accepts 32-bit instruction words over a
//  valid/ready stream and writes them into the byte-wide instruction memory array.
//  Byte order is little-endian: one byte per cycle, 4 cycles per word, from BASE_ADDR upward.
//  Sits between the program source (testbench, UART bridge or boot ROM) and the memory
//  write port; the core stays held off until done.
// PARAMETERS
//  ADDR_W     8   byte-address width; memory holds 2**ADDR_W bytes
//  BASE_ADDR  0   first byte address written; must be a multiple of 4
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        pulse: begin a new load session
//  in_valid    in   1        in_word/in_last valid
//  in_ready    out  1        loader can take a word this cycle
//  in_word     in   32       instruction word
//  in_last     in   1        final word of the program
//  mem_we      out  1        byte write strobe to instruction memory
//  mem_addr    out  ADDR_W   byte address of the write
//  mem_wdata   out  8        byte data of the write
//  busy        out  1        session active (WAIT or WRITE)
//  done        out  1        session finished; held until the next start
//  err_full    out  1        memory filled before in_last was seen; valid when done=1
//  word_count  out  ADDR_W-1 words accepted this session
//  checksum    out  32       mod-2^32 sum of accepted words this session
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output is 0; byte pointer=BASE_ADDR.
//  All outputs are registered except in_ready, which is decoded from the state register.
//  States: IDLE -> (start) WAIT -> (handshake) WRITE -> WAIT | DONE; DONE -> (start) WAIT.
//  start in IDLE/DONE: ptr=BASE_ADDR; clears word_count, checksum, done and err_full.
//  start in WAIT/WRITE: ignored.
//  in_ready=1 only in WAIT; a handshake is in_valid & in_ready at a rising edge.
//  Handshake edge k: latch in_word and in_last; word_count+=1; checksum+=in_word.
//   The same edge registers byte 0: mem_we=1, mem_addr=ptr, mem_wdata=in_word[7:0].
//  Edges k+1..k+3: bytes 1..3 (in_word[15:8], [23:16], [31:24]) go to ptr+1..ptr+3.
//   The byte pointer advances by 1 on each written byte.
//  Edge k+3: next state is chosen:
//   DONE if in_last latched, or if ptr+3 == 2**ADDR_W-1 (memory full);
//   otherwise WAIT.
//   So in_ready=1 in the cycle after edge k+3.
//   A handshake at k+4 writes continuously: 4 cycles/word with no gap.
//  With no handshake at k+4: mem_we=0 and mem_addr/mem_wdata hold their last values.
//  DONE: done=1, busy=0, in_ready=0. err_full=1 iff full was reached without in_last.
//   When in_last coincides with full, err_full=0.
//  Pointer arithmetic is ADDR_W bits; the full check stops it before wrap, so it never wraps.
//  in_valid in IDLE/DONE/WRITE: ignored; the word is not consumed.
//  The source must hold in_word stable until in_ready.
//  start and rst_n together: reset wins.
//  rst_n low mid-word: mem_we drops immediately; the partial word stays in memory.
//   A later start rewrites from BASE_ADDR.
//  Capacity is (2**ADDR_W - BASE_ADDR)/4 words (64 at the defaults).
// TESTING
//  1. reset; start; one word 0x00500093 with last=1 -> mem_we for 4 cycles writing
//     93@00, 00@01, 50@02, 00@03; then done=1, word_count=1, checksum=0x00500093, err_full=0.
//  2. start; 3 words with in_valid held high, last on the 3rd -> 12 consecutive mem_we
//     cycles at addr 0x00..0x0B with no gaps; checksum = sum of the 3 words.
//  3. in_valid gaps of 0-5 random cycles over 10 words -> byte image matches a reference
//     model exactly; no duplicate and no missing writes; in_ready low during WRITE.
//  4. 64 words with last on the 64th -> final write at 0xFF; done=1, err_full=0.
//     Repeat offering 65 words -> DONE after 64, err_full=1, word_count=64, 65th not consumed.
//  5. rst_n low during byte 2 of word 5 -> all outputs 0 asynchronously, no further mem_we.
//     Then start -> the first write is at BASE_ADDR and word_count restarts from 0.
//  6. start pulsed in WAIT and in WRITE -> no effect.
//     start in DONE -> done/err_full/word_count/checksum cleared and in_ready=1 next cycle.

Source files
------------

// File: rtl/insmem_loader.sv
// insmem_loader: write-side companion to the byte-wide instruction memory.
// Takes 32-bit instruction words over a valid/ready stream and writes each
// one little-endian, one byte per cycle, from BASE_ADDR upward.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               pulse: begin a new load session (IDLE/DONE only)
//   i_in_valid/o_in_ready word stream handshake; o_in_ready high only in WAIT
//   i_in_word, i_in_last  instruction word, final-word marker
//   o_mem_we/addr/wdata   byte write port to instruction memory
//   o_busy                session active (WAIT or WRITE)
//   o_done                session finished; held until the next start
//   o_err_full            memory filled before the last word was seen
//   o_word_count          words accepted this session
//   o_checksum            mod-2^32 sum of accepted words this session
module insmem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_in_word,
  input  logic              i_in_last,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_full,
  output logic [ADDR_W-2:0] o_word_count,
  output logic [31:0]       o_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP     = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-2:0] WC_ONE  = (ADDR_W-1)'(1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [1:0]        r_bidx;
  logic [31:0]       r_word;
  logic              r_last;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_busy, r_done, r_err_full;
  logic [ADDR_W-2:0] r_word_count;
  logic [31:0]       r_checksum;

  logic w_hs, w_start, w_last_byte, w_full;

  assign w_hs        = (r_state == S_WAIT) && i_in_valid;
  assign w_start     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_byte = (r_state == S_WRITE) && (r_bidx == 2'd3);
  // On the last byte of a word the pointer is the address being written;
  // hitting the top address means the array is full.
  assign w_full      = (r_ptr == TOP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_WAIT;
      S_WAIT:  if (i_in_valid) w_next = S_WRITE;
      S_WRITE: if (r_bidx == 2'd3) w_next = (r_last || w_full) ? S_DONE : S_WAIT;
      S_DONE:  if (i_start) w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr        <= BASE;
      r_bidx       <= 2'd0;
      r_word       <= '0;
      r_last       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_full   <= 1'b0;
      r_word_count <= '0;
      r_checksum   <= '0;
    end else begin
      r_busy   <= (w_next == S_WAIT) || (w_next == S_WRITE);
      r_done   <= (w_next == S_DONE);
      r_mem_we <= 1'b0;  // addr/wdata hold when no byte is written

      if (w_start) begin
        r_ptr        <= BASE;
        r_word_count <= '0;
        r_checksum   <= '0;
        r_err_full   <= 1'b0;
      end

      // Handshake edge: latch the word and write byte 0 straight from the input.
      if (w_hs) begin
        r_word       <= i_in_word;
        r_last       <= i_in_last;
        r_word_count <= r_word_count + WC_ONE;
        r_checksum   <= r_checksum + i_in_word;
        r_mem_we     <= 1'b1;
        r_mem_addr   <= r_ptr;
        r_mem_wdata  <= i_in_word[7:0];
        r_ptr        <= r_ptr + PTR_ONE;
        r_bidx       <= 2'd1;
      end

      if (r_state == S_WRITE) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_ptr;
        r_mem_wdata <= r_word[8*r_bidx +: 8];
        r_bidx      <= r_bidx + 2'd1;
        // Hold the pointer at the top address instead of wrapping to zero.
        if (!(w_last_byte && w_full)) r_ptr <= r_ptr + PTR_ONE;
        if (w_last_byte && w_full && !r_last) r_err_full <= 1'b1;
      end
    end
  end

  assign o_in_ready   = (r_state == S_WAIT);
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err_full   = r_err_full;
  assign o_word_count = r_word_count;
  assign o_checksum   = r_checksum;

endmodule
